// File: rtl/ula_seq.sv
// ula_seq: registered ALU with add/sub/logic ops, bit-serial shifts,
// Z/N/C/V flags and a start/done handshake.
`default_nettype none

module ula_seq #(
  parameter int WIDTH   = 11,
  parameter int SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [2:0]       operation_i,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             z_o,
  output logic             n_o,
  output logic             c_o,
  output logic             v_o
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;

  localparam logic [1:0] SH_SLL = 2'b01;
  localparam logic [1:0] SH_SRL = 2'b10;

  state_t             state_q, state_d;
  logic [SHAMT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [1:0]         sop_q, sop_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               z_q, z_d, n_q, n_d, c_q, c_d, v_q, v_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] amt;
  logic               is_shift;
  logic [WIDTH:0]     sum;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c, alu_v;
  logic [WIDTH-1:0]   sh_res;
  logic               sh_c;

  assign amt      = operand2_i[SHAMT_W-1:0];
  assign is_shift = operation_i[2] & (operation_i[1] | operation_i[0]);

  // Single-cycle datapath; a shift by zero falls through to the default arm.
  always_comb begin
    sum     = '0;
    alu_res = operand1_i;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (operation_i)
      OP_ADD: begin
        sum     = {1'b0, operand1_i} + {1'b0, operand2_i};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operand1_i[WIDTH-1] == operand2_i[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != operand1_i[WIDTH-1]);
      end
      OP_SUB: begin
        sum     = {1'b0, operand1_i} + {1'b0, ~operand2_i} + {{WIDTH{1'b0}}, 1'b1};
        alu_res = sum[WIDTH-1:0];
        alu_c   = sum[WIDTH];
        alu_v   = (operand1_i[WIDTH-1] != operand2_i[WIDTH-1]) &&
                  (alu_res[WIDTH-1] != operand1_i[WIDTH-1]);
      end
      OP_AND:  alu_res = operand1_i & operand2_i;
      OP_OR:   alu_res = operand1_i | operand2_i;
      OP_XOR:  alu_res = operand1_i ^ operand2_i;
      default: alu_res = operand1_i;
    endcase
  end

  always_comb begin
    case (sop_q)
      SH_SLL: begin
        sh_res = {work_q[WIDTH-2:0], 1'b0};
        sh_c   = work_q[WIDTH-1];
      end
      SH_SRL: begin
        sh_res = {1'b0, work_q[WIDTH-1:1]};
        sh_c   = work_q[0];
      end
      default: begin
        sh_res = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
        sh_c   = work_q[0];
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    work_d   = work_q;
    sop_d    = sop_q;
    result_d = result_q;
    z_d      = z_q;
    n_d      = n_q;
    c_d      = c_q;
    v_d      = v_q;
    done_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (is_shift && (amt != '0)) begin
            work_d  = operand1_i;
            cnt_d   = amt;
            sop_d   = operation_i[1:0];
            state_d = SHIFT;
          end else begin
            result_d = alu_res;
            z_d      = (alu_res == '0);
            n_d      = alu_res[WIDTH-1];
            c_d      = alu_c;
            v_d      = alu_v;
            done_d   = 1'b1;
          end
        end
      end
      SHIFT: begin
        work_d = sh_res;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = sh_res;
          z_d      = (sh_res == '0);
          n_d      = sh_res[WIDTH-1];
          c_d      = sh_c;
          v_d      = 1'b0;
          done_d   = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      work_q   <= '0;
      sop_q    <= '0;
      result_q <= '0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
      c_q      <= 1'b0;
      v_q      <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      work_q   <= work_d;
      sop_q    <= sop_d;
      result_q <= result_d;
      z_q      <= z_d;
      n_q      <= n_d;
      c_q      <= c_d;
      v_q      <= v_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = (state_q == SHIFT);
  assign done_o   = done_q;
  assign result_o = result_q;
  assign z_o      = z_q;
  assign n_o      = n_q;
  assign c_o      = c_q;
  assign v_o      = v_q;

endmodule

`default_nettype wire

// File: tb/tb_ula_seq.sv
// tb_ula_seq: scoreboard bench for ula_seq (WIDTH=11) against an arithmetic reference model.
`default_nettype none

module tb_ula_seq;

  localparam int W = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start_i = 1'b0;
  logic [2:0]   operation_i = '0;
  logic [W-1:0] operand1_i = '0;
  logic [W-1:0] operand2_i = '0;
  logic         busy_o, done_o, z_o, n_o, c_o, v_o;
  logic [W-1:0] result_o;

  ula_seq #(.WIDTH(W), .SHAMT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .operation_i(operation_i),
    .operand1_i(operand1_i), .operand2_i(operand2_i), .busy_o(busy_o),
    .done_o(done_o), .result_o(result_o), .z_o(z_o), .n_o(n_o), .c_o(c_o), .v_o(v_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          r;
    int          z, n, c, v;
    int unsigned cyc;
  } exp_t;

  exp_t        q[$];
  int unsigned cyc = 0;
  int          tests = 0;
  int          failed = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input int act, input int expv);
    tests++;
    if (act != expv) begin
      failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endfunction

  function automatic int sgn(input int x);
    return (x >= 1024) ? x - 2048 : x;
  endfunction

  function automatic exp_t model(input int op, input int a, input int b);
    exp_t e;
    int   s, k, sa, sb;
    sa = sgn(a);
    sb = sgn(b);
    k  = b % 16;
    e.c = 0;
    e.v = 0;
    e.cyc = 0;
    case (op)
      0: begin
        s = a + b;
        e.r = s % 2048;
        e.c = (s >= 2048);
        e.v = ((sa + sb) > 1023) || ((sa + sb) < -1024);
      end
      1: begin
        s = a + (2047 - b) + 1;
        e.r = s % 2048;
        e.c = (s >= 2048);
        e.v = ((sa - sb) > 1023) || ((sa - sb) < -1024);
      end
      2: e.r = a & b;
      3: e.r = a | b;
      4: e.r = a ^ b;
      5: begin
        e.r = (a * (1 << k)) % 2048;
        e.c = (k == 0 || k > W) ? 0 : ((a >> (W - k)) & 1);
      end
      6: begin
        e.r = a >> k;
        e.c = (k == 0 || k > W) ? 0 : ((a >> (k - 1)) & 1);
      end
      default: begin
        e.r = (sa >>> k) & 2047;
        e.c = (k == 0) ? 0 : ((sa >>> (k - 1)) & 1);
      end
    endcase
    e.z = (e.r == 0);
    e.n = (e.r >= 1024);
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation, on time.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (done_o) begin
        if (q.size() == 0) begin
          chk("spurious_done", 1, 0);
        end else begin
          e = q.pop_front();
          chk("result", int'(result_o), e.r);
          chk("z", int'(z_o), e.z);
          chk("n", int'(n_o), e.n);
          chk("c", int'(c_o), e.c);
          chk("v", int'(v_o), e.v);
          chk("done_cycle", int'(cyc), int'(e.cyc));
        end
      end else if (q.size() > 0 && cyc > q[0].cyc) begin
        chk("missing_done", int'(cyc), int'(q[0].cyc));
        void'(q.pop_front());
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 of the cycle the op's done is visible.
  task automatic drive(input int op, input int a, input int b, input bit pulse);
    exp_t e;
    int   k, n;
    k = b % 16;
    start_i     = 1'b1;
    operation_i = 3'(op);
    operand1_i  = W'(a);
    operand2_i  = W'(b);
    e = model(op, a, b);
    e.cyc = cyc + 1 + ((op >= 5) ? k : 0);
    q.push_back(e);
    @(posedge clk); #1;
    start_i     = 1'b0;
    operation_i = 3'($urandom);
    operand1_i  = W'($urandom);
    operand2_i  = W'($urandom);
    if (op >= 5 && k != 0) begin
      n = 0;
      while (busy_o && n < 40) begin
        n++;
        if (pulse && n == 1 && k >= 2) begin
          start_i     = 1'b1;
          operation_i = 3'd0;
        end else begin
          start_i = 1'b0;
        end
        @(posedge clk); #1;
      end
      start_i = 1'b0;
      chk("busy_len", n, k);
    end
  endtask

  task automatic idle(input int n);
    start_i = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_done", int'(done_o), 0);
    chk("rst_result", int'(result_o), 0);
    chk("rst_flags", int'({z_o, n_o, c_o, v_o}), 0);
    rst_n = 1'b1;
    idle(2);

    drive(0, 'h3FF, 'h001, 0);
    drive(1, 'h005, 'h005, 0);
    drive(1, 'h003, 'h005, 0);
    drive(7, 'h400, 3, 1);
    idle(1);
    chk("sra_hold", int'(result_o), 'h780);
    drive(5, 'h001, 10, 0);
    drive(5, 'h001, 11, 0);
    drive(6, 'h7FF, 0, 0);
    drive(2, 'h5A5, 'h0FF, 0);
    drive(4, 'h7FF, 'h7FF, 0);
    idle(2);

    // Reset in the middle of an SRL by 8: no completion may follow.
    start_i     = 1'b1;
    operation_i = 3'd6;
    operand1_i  = W'('h6A5);
    operand2_i  = W'(8);
    @(posedge clk); #1;
    start_i = 1'b0;
    idle(2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_result", int'(result_o), 0);
    chk("mid_rst_flags", int'({done_o, z_o, n_o, c_o, v_o}), 0);
    repeat (8) begin
      @(negedge clk);
      chk("mid_rst_no_done", int'(done_o), 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    idle(1);
    chk("post_rst_idle", int'(busy_o), 0);
    drive(0, 'h123, 'h456, 0);

    for (int i = 0; i < 300; i++) begin
      drive(int'($urandom_range(0, 7)), int'($urandom_range(0, 2047)),
            int'($urandom_range(0, 2047)), bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
    end

    idle(4);
    chk("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/ula_seq.md
Name: ula_seq

Overview:
- Parametrised, registered successor to the BIP-2 combinational ALU.
- Adds logic operations, multi-cycle shifts, C/V flags and a start/done handshake.
- Sits between the datapath register file/accumulator and the control unit.
- The control unit issues one operation per start and waits for done_o before consuming the result and flags.

Parameters:
- WIDTH, 11, data width of operands and result.
- SHAMT_W, 4, width of the shift-amount field taken from operand2_i[SHAMT_W-1:0]; must satisfy 2**SHAMT_W >= WIDTH.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  request; accepted only when busy_o=0.
- operation_i  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SLL, 110 SRL, 111 SRA.
- operand1_i  input  WIDTH  first operand; the shifted value for shift ops.
- operand2_i  input  WIDTH  second operand; low SHAMT_W bits are the shift amount.
- busy_o  input/output: output  1  high while a shift is iterating.
- done_o  output  1  one-cycle pulse; result_o and flags are valid from this cycle on.
- result_o  output  WIDTH  registered result, held until the next completion.
- z_o  output  1  zero flag.
- n_o  output  1  negative flag (result MSB).
- c_o  output  1  carry / no-borrow / last bit shifted out.
- v_o  output  1  signed overflow.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset (any time, including mid-shift):
  - state=IDLE, busy_o=0, done_o=0, result_o=0, z_o=0, n_o=0, c_o=0, v_o=0.
  - Shift counter and working register are cleared.
- FSM states: IDLE, SHIFT.
- Accept: start_i=1 in IDLE at cycle T.
  - All inputs are latched at that edge.
  - Input changes after acceptance are ignored.
- Non-shift ops, or shifts with amount 0:
  - result and flags are written at the edge ending T.
  - done_o=1 in cycle T+1; state stays IDLE.
  - A start in T+1 is accepted (back-to-back, one op per cycle).
- Shift ops with amount k>0:
  - The edge ending T loads the working register with operand1_i and the counter with k; state goes to SHIFT and busy_o=1.
  - Each SHIFT edge shifts by one bit and decrements the counter.
  - The edge with counter=1 writes result_o and flags, pulses done_o (visible in cycle T+1+k), and returns to IDLE.
  - busy_o is high for k cycles (T+1 .. T+k).
- start_i while busy_o=1: ignored, with no queuing.
- Arithmetic is modulo 2**WIDTH.
  - ADD: {c,r} = op1+op2.
  - SUB: {c,r} = op1 + ~op2 + 1, so c=1 means no borrow (op1 >= op2 unsigned).
  - V (ADD/SUB only) = two's-complement signed overflow.
- Logic ops: c_o=0, v_o=0.
- Shifts:
  - SLL/SRL fill with 0; SRA fills with op1 MSB.
  - c_o = last bit shifted out (0 when k=0); v_o=0.
  - Amounts >= WIDTH are iterated fully: SLL/SRL give 0, SRA gives all sign bits.
- All ops: z_o = (result==0), n_o = result[WIDTH-1].
- result_o and flags change only on completion edges; done_o is never high for two consecutive cycles on a single op.

Test Plan (WIDTH=11):
- Reset, then ADD 0x3FF+0x001 -> done at T+1; result 0x400, n=1, v=1, c=0, z=0.
- SUB 0x005-0x005 -> result 0x000, z=1, c=1, v=0. Then SUB 0x003-0x005 in the next cycle (back-to-back) -> result 0x7FE, n=1, c=0.
- SRA 0x400 by 3 -> busy_o high 3 cycles, done at T+4, result 0x780, n=1, c=0.
  - start_i pulsed during busy with ADD is ignored; result stays 0x780.
- SLL 0x001 by 10 -> result 0x400, c=0. SLL 0x001 by 11 -> result 0x000, z=1, c=1. SRL 0x7FF by 0 -> done at T+1, result 0x7FF, c=0.
- AND 0x5A5 & 0x0FF -> 0x0A5, c=0, v=0. XOR 0x7FF ^ 0x7FF -> 0x000, z=1.
- Start SRL by 8, assert rst_n=0 at cycle T+3 -> all outputs 0 immediately, no done pulse. After release, a new ADD completes normally.
